// File: rtl/p_cache_if.sv
// p_cache_if: fetch-side and program-memory-side signals of the program cache.
// The cache connects through the slave modport; the PC stage / memory
// environment uses the master modport.
interface p_cache_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  logic [ADDR_W-1:0] A;
  logic              invalidate;
  logic [DATA_W-1:0] I;
  logic              p_cache_miss;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;

  modport master (
    output A, invalidate, mem_ack, mem_data,
    input  I, p_cache_miss, mem_req, mem_addr
  );

  modport slave (
    input  A, invalidate, mem_ack, mem_data,
    output I, p_cache_miss, mem_req, mem_addr
  );
endinterface

// File: rtl/p_cache.sv
// p_cache: direct-mapped read-only program cache with one-line refill on miss.
// A hit returns the word one cycle after the address edge; a miss holds
// p_cache_miss high through FILL and a single REPLAY cycle.
// Optional hit/miss counters are built when P_CACHE_STATS_EN is defined.
module p_cache #(
  parameter int LINES_LOG2 = 4,
  parameter int WORDS_LOG2 = 3,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16
) (
  input  logic      clk,
  input  logic      rst,
  p_cache_if.slave  bus
`ifdef P_CACHE_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int LINES  = 1 << LINES_LOG2;
  localparam int IX_W   = LINES_LOG2 + WORDS_LOG2;
  localparam int TAG_W  = ADDR_W - IX_W;
  localparam int LINE_W = ADDR_W - WORDS_LOG2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_REPLAY = 2'd2;

  logic [1:0]            r_state;
  logic [ADDR_W-1:0]     r_a;
  logic                  r_lookup_valid;
  logic [LINES-1:0]      r_valid;
  logic [LINE_W-1:0]     r_fill_line;   // {tag, index} of the line being refilled
  logic [WORDS_LOG2-1:0] r_fill_cnt;
  logic [DATA_W-1:0]     r_data_mem [0:(1<<IX_W)-1];
  logic [TAG_W-1:0]      r_tag_mem  [0:LINES-1];
  logic [DATA_W-1:0]     r_data_q;
  logic [TAG_W-1:0]      r_tag_q;

  logic [LINES_LOG2-1:0] w_a_idx;
  logic [TAG_W-1:0]      w_a_tag;
  logic                  w_hit;
  logic                  w_miss_idle;
  logic [IX_W-1:0]       w_rd_ix;
  logic [LINES_LOG2-1:0] w_fill_idx;
  logic                  w_fill_wr;
  logic                  w_fill_last;
  logic [LINES-1:0]      w_valid_next;

  assign w_a_idx     = r_a[WORDS_LOG2 +: LINES_LOG2];
  assign w_a_tag     = r_a[ADDR_W-1 -: TAG_W];
  assign w_hit       = r_lookup_valid & r_valid[w_a_idx] & (r_tag_q == w_a_tag);
  assign w_miss_idle = (r_state == S_IDLE) & r_lookup_valid & ~w_hit;
  // New fetches are read in IDLE; REPLAY re-reads the held address.
  assign w_rd_ix     = (r_state == S_IDLE) ? bus.A[IX_W-1:0] : r_a[IX_W-1:0];
  assign w_fill_idx  = r_fill_line[LINES_LOG2-1:0];
  assign w_fill_wr   = (r_state == S_FILL) & bus.mem_ack;
  assign w_fill_last = w_fill_wr & (r_fill_cnt == {WORDS_LOG2{1'b1}});

  assign bus.I            = r_data_q;
  assign bus.p_cache_miss = (r_state != S_IDLE) | w_miss_idle;
  assign bus.mem_req      = (r_state == S_FILL);
  assign bus.mem_addr     = {r_fill_line, r_fill_cnt};

  // Per-line valid update: completing fill beats invalidate, invalidate beats miss-clear.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    assign w_valid_next[gi] =
      (w_fill_last && (w_fill_idx == LINES_LOG2'(gi))) ? 1'b1 :
      bus.invalidate                                   ? 1'b0 :
      (w_miss_idle && (w_a_idx == LINES_LOG2'(gi)))    ? 1'b0 :
      r_valid[gi];
  end

  // Valid flop vector.
  always_ff @(posedge clk) begin
    if (rst) r_valid <= '0;
    else     r_valid <= w_valid_next;
  end

  // Lookup / refill sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_a            <= '0;
      r_lookup_valid <= 1'b0;
      r_fill_line    <= '0;
      r_fill_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_miss_idle) begin
            r_state     <= S_FILL;
            r_fill_line <= r_a[ADDR_W-1:WORDS_LOG2];
            r_fill_cnt  <= '0;
          end else begin
            r_a            <= bus.A;
            r_lookup_valid <= 1'b1;
          end
        end
        S_FILL: begin
          if (bus.mem_ack) begin
            r_fill_cnt <= r_fill_cnt + 1'b1;
            if (r_fill_cnt == {WORDS_LOG2{1'b1}}) r_state <= S_REPLAY;
          end
        end
        S_REPLAY: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Data array write port: one word per acknowledged beat.
  always_ff @(posedge clk) begin
    if (w_fill_wr) r_data_mem[{w_fill_idx, r_fill_cnt}] <= bus.mem_data;
  end

  // Data array registered read; the output register clears on reset so I starts at 0.
  always_ff @(posedge clk) begin
    if (rst) r_data_q <= '0;
    else     r_data_q <= r_data_mem[w_rd_ix];
  end

  // Tag array write on the final beat of a refill.
  always_ff @(posedge clk) begin
    if (w_fill_last) r_tag_mem[w_fill_idx] <= r_fill_line[LINE_W-1 -: TAG_W];
  end

  // Tag array registered read, same address as the data read.
  always_ff @(posedge clk) begin
    r_tag_q <= r_tag_mem[w_rd_ix[IX_W-1:WORDS_LOG2]];
  end

`ifdef P_CACHE_STATS_EN
  logic w_hit_inc;
  assign w_hit_inc = (r_state == S_IDLE) & r_lookup_valid & w_hit;

  // Saturating hit/miss counters; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (w_hit_inc && (hit_count != 16'hFFFF))    hit_count  <= hit_count + 16'd1;
      if (w_miss_idle && (miss_count != 16'hFFFF)) miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_p_cache.sv
// tb_p_cache: directed vector table, reset-abort and invalidate sequences,
// then random fetches checked against a line-level cache model.
module tb_p_cache;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  p_cache_if #(.ADDR_W(16), .DATA_W(16)) bus ();

`ifdef P_CACHE_STATS_EN
  logic        stats_clr;
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  p_cache dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef P_CACHE_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return 16'hA000 + a;
  endfunction

  // Program memory responder: acks after mem_delay wait cycles, records addresses.
  int          mem_delay = 0;
  logic [15:0] ack_q[$];
  initial begin
    int          wait_cnt;
    logic [15:0] held;
    wait_cnt = 0;
    held = '0;
    bus.mem_ack  = 1'b0;
    bus.mem_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_req) begin
        if (wait_cnt == 0) held = bus.mem_addr;
        else check("mem_addr_stable", bus.mem_addr, held);
        if (wait_cnt >= mem_delay) begin
          bus.mem_ack  = 1'b1;
          bus.mem_data = mem_fn(bus.mem_addr);
          ack_q.push_back(bus.mem_addr);
          wait_cnt = 0;
        end else begin
          bus.mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus.mem_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Line-level model: which lines hold which tags.
  bit         m_valid[16];
  logic [8:0] m_tag[16];

  function automatic bit model_miss(input logic [15:0] a, input int mode);
    return (mode == 1) || !m_valid[a[6:3]] || (m_tag[a[6:3]] != a[15:7]);
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
  endfunction

  function automatic void model_update(input logic [15:0] a, input int mode);
    bit miss;
    miss = model_miss(a, mode);
    if (mode == 1) model_clear();
    if (miss) begin
      if (mode == 2) model_clear();
      m_valid[a[6:3]] = 1'b1;
      m_tag[a[6:3]]   = a[15:7];
    end
  endfunction

  // One fetch; entered and left at a negedge of a non-miss cycle.
  // mode 0: plain, 1: invalidate with the address edge, 2: invalidate on final-ack edge.
  task automatic fetch(input string name, input logic [15:0] addr, input int delay,
                       input int mode, input int exp_cycles, input logic [15:0] exp_i);
    int cnt;
    int bad;
    bit done;
    mem_delay = delay;
    ack_q.delete();
    bus.A = addr;
    if (mode == 1) bus.invalidate = 1'b1;
    @(posedge clk);
    #1;
    bus.invalidate = 1'b0;
`ifdef P_CACHE_STATS_EN
    stats_clr = 1'b0;
`endif
    cnt = 0;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (!bus.p_cache_miss) done = 1'b1;
      else begin
        cnt++;
        if (mode == 2 && bus.mem_req && bus.mem_ack && bus.mem_addr[2:0] == 3'd7) begin
          bus.invalidate = 1'b1;
          @(posedge clk);
          #1;
          bus.invalidate = 1'b0;
        end
      end
    end
    $display("fetch %s A=%h delay=%0d mode=%0d miss_cycles=%0d I=%h", name, addr, delay, mode, cnt, bus.I);
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_miss_cycles"}, cnt, exp_cycles);
    check({name, "_I"}, bus.I, exp_i);
    check({name, "_acks"}, ack_q.size(), (exp_cycles > 0) ? 8 : 0);
    bad = 0;
    foreach (ack_q[k]) if (ack_q[k] != ({addr[15:3], 3'b000} + 16'(k))) bad++;
    check({name, "_ack_addr_errs"}, bad, 0);
    model_update(addr, mode);
  endtask

  typedef struct {
    logic [15:0] addr;
    int          delay;
    int          mode;
    int          exp_cycles;
    logic [15:0] exp_i;
  } vec_t;

  vec_t tab[13];

  initial begin
    logic [8:0] tags[4];
    int acks;
    tab[0]  = '{16'h0000, 0, 0, 10, 16'hA000};
    tab[1]  = '{16'h0003, 0, 0,  0, 16'hA003};
    tab[2]  = '{16'h0080, 0, 0, 10, 16'hA080};
    tab[3]  = '{16'h0000, 0, 0, 10, 16'hA000};
    tab[4]  = '{16'h0008, 3, 0, 34, 16'hA008};
    tab[5]  = '{16'h000F, 0, 0,  0, 16'hA00F};
    tab[6]  = '{16'h0010, 0, 0, 10, 16'hA010};
    tab[7]  = '{16'h0008, 0, 1, 10, 16'hA008};
    tab[8]  = '{16'h0010, 0, 0, 10, 16'hA010};
    tab[9]  = '{16'h0000, 0, 0, 10, 16'hA000};
    tab[10] = '{16'h0020, 0, 2, 10, 16'hA020};
    tab[11] = '{16'h0008, 0, 0, 10, 16'hA008};
    tab[12] = '{16'h0024, 0, 0,  0, 16'hA024};

    rst = 1'b1;
    bus.A = '0;
    bus.invalidate = 1'b0;
`ifdef P_CACHE_STATS_EN
    stats_clr = 1'b0;
`endif
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_I", bus.I, 16'h0000);
    check("rst_miss", 32'(bus.p_cache_miss), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 16'h0000);
`ifdef P_CACHE_STATS_EN
    check("rst_hit_count", hit_count, 16'd0);
    check("rst_miss_count", miss_count, 16'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 13; i++)
      fetch($sformatf("v%0d", i), tab[i].addr, tab[i].delay, tab[i].mode, tab[i].exp_cycles, tab[i].exp_i);

    // Reset one cycle after the 4th beat of a refill aborts it.
    bus.A = 16'h0100;
    mem_delay = 1;
    @(posedge clk);
    acks = 0;
    for (int n = 0; n < 200 && acks < 4; n++) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_ack) acks++;
    end
    check("abort_acks_seen", acks, 4);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_mem_req", 32'(bus.mem_req), 32'd0);
    check("abort_miss", 32'(bus.p_cache_miss), 32'd0);
    check("abort_mem_addr", bus.mem_addr, 16'h0000);
    $display("reset during fill at A=0100 applied");
    rst = 1'b0;
    model_clear();
    fetch("abort_refetch", 16'h0100, 1, 0, 18, 16'hA100);

    // Random fetches against the model.
    tags[0] = 9'h000;
    tags[1] = 9'h001;
    tags[2] = 9'h002;
    tags[3] = 9'h1FF;
    for (int r = 0; r < 40; r++) begin
      logic [15:0] a;
      int d;
      int m;
      bit miss;
      a = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
      d = $urandom_range(0, 2);
      m = ($urandom_range(0, 7) == 0) ? 1 : 0;
      miss = model_miss(a, m);
      if (miss && m == 0 && $urandom_range(0, 3) == 0) m = 2;
      fetch($sformatf("r%0d", r), a, d, m, miss ? (2 + 8 * (d + 1)) : 0, mem_fn(a));
    end

`ifdef P_CACHE_STATS_EN
    // One cold miss followed by hits; the post-replay cycle counts as the first hit.
    stats_clr = 1'b1;
    fetch("s_cold", 16'h1230, 0, 1, 10, 16'hB230);
    fetch("s_h1", 16'h1231, 0, 0, 0, 16'hB231);
    fetch("s_h2", 16'h1232, 0, 0, 0, 16'hB232);
    fetch("s_h3", 16'h1233, 0, 0, 0, 16'hB233);
    fetch("s_h4", 16'h1234, 0, 0, 0, 16'hB234);
    @(posedge clk);
    @(negedge clk);
    $display("stats hit_count=%0d miss_count=%0d", hit_count, miss_count);
    check("stats_hit_count", hit_count, 16'd5);
    check("stats_miss_count", miss_count, 16'd1);
    stats_clr = 1'b1;
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    @(negedge clk);
    $display("stats after clear hit_count=%0d miss_count=%0d", hit_count, miss_count);
    check("stats_clr_hit", hit_count, 16'd0);
    check("stats_clr_miss", miss_count, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
